// File: rtl/tc_pkg.sv
// Shared types and constants for the tensor-core result drain.
// The entry struct is the FIFO payload: one captured result row plus its address context.
package tc_pkg;

  localparam int unsigned C_DATA_WIDTH   = 128;
  localparam int unsigned ROWS           = 8;
  localparam int unsigned ADDR_WIDTH     = 16;
  localparam int unsigned FIFO_DEPTH_DEF = 4;

  localparam int unsigned BEATS_PER_ROW  = 4;
  localparam int unsigned ROW_W          = $clog2(ROWS);
  localparam int unsigned BEAT_W         = $clog2(BEATS_PER_ROW);
  localparam int unsigned WORD_W         = C_DATA_WIDTH * BEATS_PER_ROW;

  typedef struct packed {
    logic [WORD_W-1:0]     data;
    logic [ROW_W-1:0]      row;
    logic [ADDR_WIDTH-1:0] base;
  } tc_entry_t;

  // base + row*BEATS_PER_ROW + k, wrapping at the address width
  function automatic logic [ADDR_WIDTH-1:0] beat_addr(
    input logic [ADDR_WIDTH-1:0] base,
    input logic [ROW_W-1:0]      row,
    input logic [BEAT_W-1:0]     k
  );
    return base + ADDR_WIDTH'({row, k});
  endfunction

endpackage

// File: rtl/tc_sync_fifo.sv
// Single-clock FIFO with registered pointers/count; head is presented combinationally on dout.
// A push while full is accepted only when a pop happens on the same edge.
module tc_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic [WIDTH-1:0]             din,
  input  logic                         pop,
  output logic [WIDTH-1:0]             dout,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt_q;
  logic             do_push;
  logic             do_pop;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == CNT_W'(DEPTH));
    do_pop  = pop && !empty;
    do_push = push && (!full || do_pop);
    count   = cnt_q;
    dout    = mem[rd_ptr];
  end

  // Storage carries no reset; only pointers and count define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt_q  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_q <= cnt_q + CNT_W'(1);
        2'b01:   cnt_q <= cnt_q - CNT_W'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: rtl/tc_result_drain.sv
// Captures tensor-core result rows into a FIFO and serialises each row into four
// addressed beats on a valid/ready master port, with stall and sticky overflow reporting.
module tc_result_drain
  import tc_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wb_in,
  input  logic [WORD_W-1:0]         result_in,
  input  logic [ADDR_WIDTH-1:0]     base_addr_in,
  input  logic                      clear_err,
  output logic                      m_valid,
  input  logic                      m_ready,
  output logic [C_DATA_WIDTH-1:0]   m_data,
  output logic [ADDR_WIDTH-1:0]     m_addr,
  output logic                      m_last,
  output logic                      busy_out,
  output logic                      stall_out,
  output logic                      overflow_out
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  logic                  wb_q;
  logic [ROW_W-1:0]      row_q;
  logic [ADDR_WIDTH-1:0] base_q;
  logic [BEAT_W-1:0]     k_q;
  logic                  overflow_q;

  logic [ADDR_WIDTH-1:0] base_cur;
  logic [ROW_W-1:0]      row_nxt;
  tc_entry_t             entry_in;
  tc_entry_t             head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [CNT_W-1:0]      fifo_count;
  logic                  accept;
  logic                  pop;
  logic                  push;
  logic                  drop;

  // row_q is held at 0 between phases, so it is already the current row on the first wb cycle
  always_comb begin
    base_cur = (wb_in && !wb_q) ? base_addr_in : base_q;
    row_nxt  = (row_q == ROW_W'(ROWS - 1)) ? '0 : row_q + ROW_W'(1);
    entry_in = '{data: result_in, row: row_q, base: base_cur};
    accept   = !fifo_empty && m_ready;
    pop      = accept && (k_q == BEAT_W'(BEATS_PER_ROW - 1));
    push     = wb_in && (!fifo_full || pop);
    drop     = wb_in && fifo_full && !pop;
  end

  tc_sync_fifo #(
    .WIDTH ($bits(tc_entry_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (entry_in),
    .pop   (pop),
    .dout  (head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_q       <= 1'b0;
      row_q      <= '0;
      base_q     <= '0;
      k_q        <= '0;
      overflow_q <= 1'b0;
    end else begin
      wb_q <= wb_in;
      if (wb_in) begin
        row_q  <= row_nxt;
        base_q <= base_cur;
      end else begin
        row_q  <= '0;
      end
      if (pop)         k_q <= '0;
      else if (accept) k_q <= k_q + BEAT_W'(1);
      // set has priority over clear
      if (drop)           overflow_q <= 1'b1;
      else if (clear_err) overflow_q <= 1'b0;
    end
  end

  // Head entry drives the beat; outputs are zero whenever the FIFO is empty
  always_comb begin
    m_valid      = !fifo_empty;
    m_data       = '0;
    m_addr       = '0;
    m_last       = 1'b0;
    busy_out     = !fifo_empty;
    stall_out    = (fifo_count >= CNT_W'(FIFO_DEPTH - 1));
    overflow_out = overflow_q;
    if (!fifo_empty) begin
      for (int unsigned i = 0; i < BEATS_PER_ROW; i++) begin
        if (k_q == BEAT_W'(i))
          m_data = head.data[(BEATS_PER_ROW - 1 - i) * C_DATA_WIDTH +: C_DATA_WIDTH];
      end
      m_addr = beat_addr(head.base, head.row, k_q);
      m_last = (k_q == BEAT_W'(BEATS_PER_ROW - 1)) && (head.row == ROW_W'(ROWS - 1));
    end
  end

endmodule

// File: tb/tb_tc_result_drain.sv
// Directed bench for tc_result_drain: depth-4 and depth-8 instances share stimulus,
// and the instance under test is selected for observation.
module tb_tc_result_drain;
  import tc_pkg::*;

  typedef struct packed {
    logic [127:0] data;
    logic [15:0]  addr;
    logic         last;
  } beat_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         wb_in;
  logic [511:0] result_in;
  logic [15:0]  base_addr_in;
  logic         clear_err;
  logic         m_ready;

  logic         v4, l4, b4, s4, o4, v8, l8, b8, s8, o8;
  logic [127:0] d4, d8;
  logic [15:0]  a4, a8;

  logic         sel;
  logic         o_valid, o_last, o_busy, o_stall, o_ovf;
  logic [127:0] o_data;
  logic [15:0]  o_addr;

  int    vectors = 0;
  int    errors  = 0;
  logic  stall_seen;
  beat_t hold;
  beat_t got_q[$];
  beat_t exp_q[$];

  always #5 clk = ~clk;

  tc_result_drain #(.FIFO_DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .wb_in(wb_in), .result_in(result_in), .base_addr_in(base_addr_in),
    .clear_err(clear_err), .m_valid(v4), .m_ready(m_ready), .m_data(d4), .m_addr(a4),
    .m_last(l4), .busy_out(b4), .stall_out(s4), .overflow_out(o4));

  tc_result_drain #(.FIFO_DEPTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .wb_in(wb_in), .result_in(result_in), .base_addr_in(base_addr_in),
    .clear_err(clear_err), .m_valid(v8), .m_ready(m_ready), .m_data(d8), .m_addr(a8),
    .m_last(l8), .busy_out(b8), .stall_out(s8), .overflow_out(o8));

  assign o_valid = sel ? v8 : v4;
  assign o_data  = sel ? d8 : d4;
  assign o_addr  = sel ? a8 : a4;
  assign o_last  = sel ? l8 : l4;
  assign o_busy  = sel ? b8 : b4;
  assign o_stall = sel ? s8 : s4;
  assign o_ovf   = sel ? o8 : o4;

  function automatic logic [127:0] oct(input int r, input int k);
    logic [31:0] v;
    v = 32'(r + 16 * k);
    return {4{v}};
  endfunction

  function automatic logic [511:0] word(input int r);
    return {oct(r, 0), oct(r, 1), oct(r, 2), oct(r, 3)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: check hold-while-stalled, record any accepted beat, advance
  task automatic tick();
    if (stall_seen) begin
      chk("hold_valid", 128'(o_valid), 128'(1));
      chk("hold_data", o_data, hold.data);
      chk("hold_addr", 128'(o_addr), 128'(hold.addr));
      chk("hold_last", 128'(o_last), 128'(hold.last));
    end
    if (o_valid && m_ready) got_q.push_back('{o_data, o_addr, o_last});
    stall_seen = o_valid && !m_ready;
    hold       = '{o_data, o_addr, o_last};
    @(posedge clk);
    #1;
  endtask

  task automatic select(input logic s);
    sel        = s;
    stall_seen = 1'b0;
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic drive_row(input int r, input logic [15:0] base);
    wb_in        = 1'b1;
    result_in    = word(r);
    base_addr_in = (r == 0) ? base : ~base;
  endtask

  task automatic clear_pulse();
    wb_in     = 1'b0;
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
  endtask

  task automatic drain(input logic toggle);
    wb_in = 1'b0;
    for (int n = 0; n < 400 && (b4 || b8); n++) begin
      if (toggle) m_ready = ~m_ready;
      tick();
    end
    chk("drain_idle", 128'(b4 | b8), 128'(0));
  endtask

  task automatic add_exp(input logic [15:0] base, input int r0, input int r1);
    for (int r = r0; r <= r1; r++)
      for (int k = 0; k < 4; k++)
        exp_q.push_back('{oct(r, k), 16'(base + 16'(r * 4 + k)), (k == 3 && r == 7)});
  endtask

  task automatic check_beats(input string tag);
    chk({tag, "_count"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk({tag, "_data"}, got_q[i].data, exp_q[i].data);
      chk({tag, "_addr"}, 128'(got_q[i].addr), 128'(exp_q[i].addr));
      chk({tag, "_last"}, 128'(got_q[i].last), 128'(exp_q[i].last));
    end
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_data"},  o_data,         128'(0));
    chk({tag, "_addr"},  128'(o_addr),  128'(0));
    chk({tag, "_last"},  128'(o_last),  128'(0));
    chk({tag, "_busy"},  128'(o_busy),  128'(0));
    chk({tag, "_stall"}, 128'(o_stall), 128'(0));
    chk({tag, "_ovf"},   128'(o_ovf),   128'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; wb_in = 1'b0; result_in = '0; base_addr_in = '0;
    clear_err = 1'b0; m_ready = 1'b0; sel = 1'b0; stall_seen = 1'b0; hold = '0;
    repeat (2) @(posedge clk);
    #1;
    select(1'b0); chk_idle("rst4");
    select(1'b1); chk_idle("rst8");
    rst = 1'b0;
    tick();

    // Full tile, free-running sink
    select(1'b1);
    m_ready = 1'b1;
    clear_pulse();
    for (int r = 0; r < 8; r++) begin drive_row(r, 16'h0100); tick(); end
    drain(1'b0);
    add_exp(16'h0100, 0, 7);
    check_beats("tile");
    chk("tile_ovf", 128'(o_ovf), 128'(0));

    // Sink blocked through an 8-row phase on the depth-4 instance
    select(1'b0);
    m_ready = 1'b0;
    clear_pulse();
    chk("ovf_pre", 128'(o_ovf), 128'(0));
    for (int r = 0; r < 8; r++) begin
      drive_row(r, 16'h0400);
      tick();
      chk("ovf_stall", 128'(o_stall), 128'(r + 1 >= 3));
      chk("ovf_flag",  128'(o_ovf),   128'(r + 1 >= 5));
    end
    wb_in   = 1'b0;
    m_ready = 1'b1;
    drain(1'b0);
    add_exp(16'h0400, 0, 3);
    check_beats("ovf_drain");
    chk("ovf_sticky", 128'(o_ovf), 128'(1));
    clear_pulse();
    chk("ovf_clear", 128'(o_ovf), 128'(0));

    // Sink ready toggling every cycle
    select(1'b1);
    m_ready = 1'b1;
    clear_pulse();
    m_ready = 1'b0;
    for (int r = 0; r < 8; r++) begin
      drive_row(r, 16'h0500);
      m_ready = ~m_ready;
      tick();
    end
    drain(1'b1);
    m_ready = 1'b1;
    add_exp(16'h0500, 0, 7);
    check_beats("toggle");

    // Short phase, gap, then a full phase at a new base
    select(1'b1);
    m_ready = 1'b1;
    for (int r = 0; r < 3; r++) begin drive_row(r, 16'h0200); tick(); end
    wb_in = 1'b0;
    tick(); tick();
    for (int r = 0; r < 8; r++) begin drive_row(r, 16'h0300); tick(); end
    drain(1'b0);
    add_exp(16'h0200, 0, 2);
    add_exp(16'h0300, 0, 7);
    check_beats("phases");

    // Full FIFO with a capture on the popping edge
    select(1'b0);
    clear_pulse();
    m_ready = 1'b0;
    for (int r = 0; r < 4; r++) begin drive_row(r, 16'h0600); tick(); end
    wb_in = 1'b0;
    chk("full_stall", 128'(o_stall), 128'(1));
    m_ready = 1'b1;
    tick(); tick(); tick();
    drive_row(0, 16'h0700);
    tick();
    wb_in = 1'b0;
    chk("full_ovf",   128'(o_ovf),   128'(0));
    chk("full_stall2", 128'(o_stall), 128'(1));
    chk("full_head",  128'(o_addr),  128'(16'h0604));
    drain(1'b0);
    add_exp(16'h0600, 0, 3);
    add_exp(16'h0700, 0, 0);
    check_beats("full_pop");
    chk("full_ovf2", 128'(o_ovf), 128'(0));

    // Reset in the middle of a row
    select(1'b0);
    m_ready = 1'b1;
    drive_row(0, 16'h0800); tick();
    drive_row(1, 16'h0800); tick();
    wb_in = 1'b0;
    tick(); tick();
    chk("mid_valid", 128'(o_valid), 128'(1));
    rst = 1'b1;
    stall_seen = 1'b0;
    @(posedge clk);
    #1;
    select(1'b0); chk_idle("mid_rst4");
    select(1'b1); chk_idle("mid_rst8");
    select(1'b0);
    rst = 1'b0;
    for (int n = 0; n < 6; n++) tick();
    check_beats("post_rst");
    chk("post_rst_valid", 128'(o_valid), 128'(0));
    drive_row(0, 16'h0900); tick();
    drain(1'b0);
    add_exp(16'h0900, 0, 0);
    check_beats("restart");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
